// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit with architectural HI/LO registers, sitting
//   beside the ALU in the EX stage.  MULT/MULTU/DIV/DIVU take WIDTH cycles;
//   MTHI/MTLO complete at their accept edge.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        EX holds a mul/div/mt instruction this cycle
//   op[2:0]      001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO,
//                000/111 no-op
//   a, b         forwarded rs / rt operands
//   read_hilo    EX holds MFHI/MFLO
//   hi, lo       architectural HI/LO
//   busy         iteration in progress
//   done         one-cycle pulse when HI/LO were written by a mul/div
//   div_by_zero  last accepted divide had b == 0 (cleared by the next accept)
//   stall        busy & (start | read_hilo), combinational
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             read_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Context latched at the accept edge and held for the whole iteration.
  typedef struct packed {
    logic             is_div;
    logic             neg_q;   // negate product (mul) / quotient (div)
    logic             neg_r;   // negate remainder
    logic             dz;      // divisor was zero
    logic [WIDTH-1:0] opd;     // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] a_raw;   // original dividend, returned on divide by zero
  } ctx_t;

  state_t           state, state_nxt;
  ctx_t             ctx;
  logic [CNT_W-1:0] cnt;
  // Working pair: mul = {partial high, multiplier shifting out};
  //               div = {partial remainder, dividend shifting out / quotient in}.
  logic [WIDTH-1:0] ph, pl;
  logic [WIDTH-1:0] ph_n, pl_n;

  logic             is_mul, is_div, is_sgn, is_mthi, is_mtlo;
  logic             accept, accept_md, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum, trial;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  // ---------------------------------------------------------------- decode
  always_comb begin
    is_mul  = (op == OP_MULT) | (op == OP_MULTU);
    is_div  = (op == OP_DIV)  | (op == OP_DIVU);
    is_sgn  = (op == OP_MULT) | (op == OP_DIV);
    is_mthi = (op == OP_MTHI);
    is_mtlo = (op == OP_MTLO);
  end

  assign accept    = start & (state == S_IDLE);
  assign accept_md = accept & (is_mul | is_div);
  assign last      = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));

  assign a_mag = (is_sgn & a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_sgn & b[WIDTH-1]) ? -b : b;

  // ---------------------------------------------------------------- FSM
  // The finish step is folded into the last RUN edge, so two states suffice.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_md) state_nxt = S_RUN;
      S_RUN:   if (last)      state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  // Only depends on the current state register and live inputs.
  assign stall = busy & (start | read_hilo);

  // ---------------------------------------------------------------- iteration
  // Shift-add: add multiplicand into the high half when the multiplier LSB is
  // set, then shift the whole pair right by one.
  assign add_sum = {1'b0, ph} + (pl[0] ? {1'b0, ctx.opd} : {(WIDTH+1){1'b0}});
  // Restoring divide: trial subtract of the divisor from the shifted remainder;
  // the top bit of the difference is the borrow (remainder < divisor).
  assign trial   = {ph, pl[WIDTH-1]} - {1'b0, ctx.opd};

  always_comb begin
    ph_n = ph;
    pl_n = pl;
    if (ctx.is_div) begin
      if (!trial[WIDTH]) begin
        ph_n = trial[WIDTH-1:0];
        pl_n = {pl[WIDTH-2:0], 1'b1};
      end else begin
        ph_n = {ph[WIDTH-2:0], pl[WIDTH-1]};
        pl_n = {pl[WIDTH-2:0], 1'b0};
      end
    end else begin
      ph_n = add_sum[WIDTH:1];
      pl_n = {add_sum[0], pl[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's outputs so HI/LO are written
  // with the finished result on the same edge.
  assign prod   = {ph_n, pl_n};
  assign prod_s = ctx.neg_q ? -prod : prod;

  always_comb begin
    fin_hi = prod_s[2*WIDTH-1:WIDTH];
    fin_lo = prod_s[WIDTH-1:0];
    if (ctx.is_div) begin
      if (ctx.dz) begin
        fin_hi = ctx.a_raw;
        fin_lo = '1;
      end else begin
        fin_hi = ctx.neg_r ? -ph_n : ph_n;
        fin_lo = ctx.neg_q ? -pl_n : pl_n;
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctx         <= '0;
      cnt         <= '0;
      ph          <= '0;
      pl          <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        if (is_mul | is_div) begin
          ctx.is_div  <= is_div;
          ctx.neg_q   <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          ctx.neg_r   <= is_sgn & a[WIDTH-1];
          ctx.dz      <= (b == '0);
          ctx.opd     <= is_mul ? a_mag : b_mag;
          ctx.a_raw   <= a;
          ph          <= '0;
          pl          <= is_mul ? b_mag : a_mag;
          cnt         <= '0;
          div_by_zero <= is_div & (b == '0);
        end else if (is_mthi) begin
          hi          <= a;
          div_by_zero <= 1'b0;
        end else if (is_mtlo) begin
          lo          <= a;
          div_by_zero <= 1'b0;
        end
      end else if (state == S_RUN) begin
        ph  <= ph_n;
        pl  <= pl_n;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          hi <= fin_hi;
          lo <= fin_lo;
        end
      end
    end
  end

endmodule
